// File: rtl/indirect_chain_if.sv
// rtl/indirect_chain_if.sv - memory request/response bus used on both sides of indirect_chain
interface indirect_chain_if #(
    parameter int DATA_W = 16
) ();
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_W-1:0]     mem_address;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_byte_enable;
    logic                  mem_resp;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  mem_resp, mem_rdata
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output mem_resp, mem_rdata
    );
endinterface

// File: rtl/indirect_chain.sv
// rtl/indirect_chain.sv - multi-level indirect memory adapter between pipeline and data cache
module indirect_chain #(
    parameter int DATA_W     = 16,
    parameter int MAX_LEVELS = 2,
    parameter int LVL_W      = $clog2(MAX_LEVELS + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    indirect_chain_if.slave   p_bus,
    indirect_chain_if.master  d_bus,
    input  logic [LVL_W-1:0]  P_levels,
    input  logic              abort,
    output logic              busy
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        TURN   = 2'd2,
        ACCESS = 2'd3
    } state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  ptr_q;
    logic [LVL_W-1:0]   remain_q;
    logic               op_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [BE_W-1:0]    be_q;
    logic               abort_q;

    logic [LVL_W-1:0]   lvl_clamped;
    logic               p_req;
    logic               direct;

    logic               d_read;
    logic               d_write;
    logic [DATA_W-1:0]  d_address;
    logic [DATA_W-1:0]  d_wdata;
    logic [BE_W-1:0]    d_be;
    logic               p_resp;

    assign lvl_clamped = (P_levels > LVL_W'(MAX_LEVELS)) ? LVL_W'(MAX_LEVELS) : P_levels;
    assign p_req       = p_bus.mem_read | p_bus.mem_write;
    assign direct      = (lvl_clamped == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            remain_q <= '0;
            op_q     <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
            abort_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    abort_q <= 1'b0;
                    if (p_req && !direct) begin
                        ptr_q    <= p_bus.mem_address;
                        remain_q <= lvl_clamped;
                        // a simultaneous read+write request is handled as a write
                        op_q     <= p_bus.mem_write;
                        wdata_q  <= p_bus.mem_wdata;
                        be_q     <= p_bus.mem_byte_enable;
                        state_q  <= FETCH;
                    end
                end
                FETCH: begin
                    if (abort) begin
                        abort_q <= 1'b1;
                    end
                    if (d_bus.mem_resp) begin
                        ptr_q    <= d_bus.mem_rdata;
                        remain_q <= remain_q - LVL_W'(1);
                        state_q  <= TURN;
                    end
                end
                TURN: begin
                    if (abort_q || abort) begin
                        abort_q <= 1'b0;
                        state_q <= IDLE;
                    end else if (remain_q != '0) begin
                        state_q <= FETCH;
                    end else begin
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    // the cache access already issued is completed even when aborted
                    if (d_bus.mem_resp) begin
                        abort_q <= 1'b0;
                        state_q <= IDLE;
                    end else if (abort) begin
                        abort_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_address = ptr_q;
        d_wdata   = wdata_q;
        d_be      = be_q;
        p_resp    = 1'b0;
        case (state_q)
            IDLE: begin
                d_address = p_bus.mem_address;
                d_wdata   = p_bus.mem_wdata;
                d_be      = p_bus.mem_byte_enable;
                if (direct) begin
                    d_read  = p_bus.mem_read & ~p_bus.mem_write;
                    d_write = p_bus.mem_write;
                    p_resp  = d_bus.mem_resp;
                end
            end
            FETCH: begin
                d_read = 1'b1;
                d_be   = '1;
            end
            TURN: begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end
            ACCESS: begin
                d_read  = ~op_q;
                d_write = op_q;
                p_resp  = d_bus.mem_resp & ~abort_q;
            end
            default: begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end
        endcase
        // strobes and the completion pulse drop the moment reset asserts
        if (!reset_n) begin
            d_read  = 1'b0;
            d_write = 1'b0;
            p_resp  = 1'b0;
        end
    end

    assign d_bus.mem_read        = d_read;
    assign d_bus.mem_write       = d_write;
    assign d_bus.mem_address     = d_address;
    assign d_bus.mem_wdata       = d_wdata;
    assign d_bus.mem_byte_enable = d_be;
    assign p_bus.mem_resp        = p_resp;
    assign p_bus.mem_rdata       = d_bus.mem_rdata;
    assign busy                  = (state_q != IDLE);
endmodule

// File: tb/tb_indirect_chain.sv
// tb/tb_indirect_chain.sv - directed self-checking bench for indirect_chain
module tb_indirect_chain;
    logic        clk;
    logic        reset_n;
    logic [1:0]  p_levels;
    logic        abort;
    logic        busy;

    indirect_chain_if #(.DATA_W(16)) p_bus ();
    indirect_chain_if #(.DATA_W(16)) d_bus ();

    indirect_chain #(.DATA_W(16), .MAX_LEVELS(2), .LVL_W(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .p_bus    (p_bus),
        .d_bus    (d_bus),
        .P_levels (p_levels),
        .abort    (abort),
        .busy     (busy)
    );

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [1:0]  be;
        logic [15:0] wdata;
        int          s;
        int          e;
    } txn_t;

    logic [15:0] mem [0:65535];
    txn_t        logq[$];
    int          lat;
    int          cnt;
    int          cnt_next;
    int          cyc;
    int          op_start;
    int          viol;
    int          checks;
    int          errors;
    logic        prev_strobe;
    logic        prev_resp;
    logic        prev_write;
    logic [15:0] prev_addr;
    int          cur_start;

    wire d_strobe = d_bus.mem_read | d_bus.mem_write;
    assign d_bus.mem_resp  = d_strobe && (cnt == lat - 1);
    assign d_bus.mem_rdata = mem[d_bus.mem_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cnt = 0;
        cnt_next = 0;
        cyc = 0;
        viol = 0;
        prev_strobe = 1'b0;
        prev_resp = 1'b0;
        prev_write = 1'b0;
        prev_addr = '0;
        cur_start = 0;
    end

    always @(posedge clk) begin
        cnt <= cnt_next;
        cyc <= cyc + 1;
    end

    // cache model and bus monitor: latency counting, logging, write merge, protocol checks
    always @(negedge clk) begin
        if (d_strobe) begin
            if (!prev_strobe || prev_resp) cur_start <= cyc;
            if ((prev_strobe && prev_resp) ||
                (prev_strobe && !prev_resp &&
                 (d_bus.mem_address != prev_addr || d_bus.mem_write != prev_write)))
                viol <= viol + 1;
        end
        if (d_bus.mem_resp) begin
            logq.push_back('{addr: d_bus.mem_address, wr: d_bus.mem_write,
                             be: d_bus.mem_byte_enable, wdata: d_bus.mem_wdata,
                             s: ((!prev_strobe || prev_resp) ? cyc : cur_start), e: cyc});
            if (d_bus.mem_write)
                mem[d_bus.mem_address] <= {
                    d_bus.mem_byte_enable[1] ? d_bus.mem_wdata[15:8] : mem[d_bus.mem_address][15:8],
                    d_bus.mem_byte_enable[0] ? d_bus.mem_wdata[7:0]  : mem[d_bus.mem_address][7:0]};
        end
        cnt_next    <= (d_strobe && !d_bus.mem_resp) ? cnt + 1 : 0;
        prev_strobe <= d_strobe;
        prev_resp   <= d_bus.mem_resp;
        prev_addr   <= d_bus.mem_address;
        prev_write  <= d_bus.mem_write;
    end

    task automatic mem_set(input logic [15:0] a, input logic [15:0] v);
        mem[a] <= v;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [1:0] be, input logic [1:0] lvl,
                          input int abort_at, input int max_cyc,
                          output int resp_cyc, output logic [15:0] rdata, output int idle_cyc,
                          output logic [15:0] addr0, output logic busy0, output logic busy1);
        int k;
        @(posedge clk);
        #1;
        logq.delete();
        p_bus.mem_read        = rd;
        p_bus.mem_write       = wr;
        p_bus.mem_address     = addr;
        p_bus.mem_wdata       = wdata;
        p_bus.mem_byte_enable = be;
        p_levels              = lvl;
        op_start = cyc;
        k = 0;
        resp_cyc = -1;
        idle_cyc = -1;
        rdata = '0;
        addr0 = '0;
        busy0 = 1'b0;
        busy1 = 1'b0;
        while (k < max_cyc && resp_cyc < 0) begin
            if (k == abort_at) begin
                abort = 1'b1;
                p_bus.mem_read  = 1'b0;
                p_bus.mem_write = 1'b0;
            end else begin
                abort = 1'b0;
            end
            @(negedge clk);
            if (k == 0) begin
                addr0 = d_bus.mem_address;
                busy0 = busy;
            end
            if (k == 1) busy1 = busy;
            if (k > 0 && !busy && idle_cyc < 0) idle_cyc = k;
            if (p_bus.mem_resp) begin
                resp_cyc = k;
                rdata = p_bus.mem_rdata;
            end
            @(posedge clk);
            #1;
            k++;
        end
        p_bus.mem_read  = 1'b0;
        p_bus.mem_write = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        if (!busy && idle_cyc < 0) idle_cyc = k;
    endtask

    int          r_cyc;
    int          i_cyc;
    logic [15:0] r_data;
    logic [15:0] a0;
    logic        b0;
    logic        b1;

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        abort = 1'b0;
        lat = 1;
        p_levels = 2'd0;
        p_bus.mem_read = 1'b1;
        p_bus.mem_write = 1'b0;
        p_bus.mem_address = 16'h1234;
        p_bus.mem_wdata = '0;
        p_bus.mem_byte_enable = '0;
        mem_set(16'h1234, 16'hBEEF);
        mem_set(16'h0100, 16'h2000);
        mem_set(16'h2000, 16'h5A5A);
        mem_set(16'h0010, 16'h0020);
        mem_set(16'h0020, 16'h0030);
        mem_set(16'h0030, 16'h1234);
        mem_set(16'h0040, 16'hFFFF);
        mem_set(16'hFFFF, 16'h0050);
        mem_set(16'h0050, 16'h7777);
        #12;
        chk("rst_d_read", 32'(d_bus.mem_read), 0);
        chk("rst_p_resp", 32'(p_bus.mem_resp), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_d_addr", 32'(d_bus.mem_address), 32'h1234);
        p_bus.mem_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // direct pass-through read, R=1
        lat = 1;
        run_op(1'b1, 1'b0, 16'h1234, 16'h0, 2'b11, 2'd0, -1, 6, r_cyc, r_data, i_cyc, a0, b0, b1);
        chk("dir_addr0", 32'(a0), 32'h1234);
        chk("dir_resp_cyc", 32'(r_cyc), 0);
        chk("dir_rdata", 32'(r_data), 32'hBEEF);
        chk("dir_busy0", 32'(b0), 0);

        // single-level indirect load, R=2
        lat = 2;
        run_op(1'b1, 1'b0, 16'h0100, 16'h0, 2'b11, 2'd1, -1, 20, r_cyc, r_data, i_cyc, a0, b0, b1);
        chk("ldi_resp_cyc", 32'(r_cyc), 5);
        chk("ldi_rdata", 32'(r_data), 32'h5A5A);
        chk("ldi_ntxn", 32'(logq.size()), 2);
        if (logq.size() == 2) begin
            chk("ldi_addr_a", 32'(logq[0].addr), 32'h0100);
            chk("ldi_addr_b", 32'(logq[1].addr), 32'h2000);
            chk("ldi_gap", 32'(logq[1].s - logq[0].e - 1), 1);
        end
        chk("ldi_busy0", 32'(b0), 0);
        chk("ldi_busy1", 32'(b1), 1);
        chk("ldi_idle_cyc", 32'(i_cyc), 6);

        // two-level indirect store, R=1
        lat = 1;
        run_op(1'b0, 1'b1, 16'h0010, 16'h00FF, 2'b01, 2'd2, -1, 20, r_cyc, r_data, i_cyc, a0, b0, b1);
        chk("sti_resp_cyc", 32'(r_cyc), 5);
        chk("sti_ntxn", 32'(logq.size()), 3);
        if (logq.size() == 3) begin
            chk("sti_f0_addr", 32'(logq[0].addr), 32'h0010);
            chk("sti_f0_wr", 32'(logq[0].wr), 0);
            chk("sti_f0_be", 32'(logq[0].be), 3);
            chk("sti_f1_addr", 32'(logq[1].addr), 32'h0020);
            chk("sti_f1_be", 32'(logq[1].be), 3);
            chk("sti_w_addr", 32'(logq[2].addr), 32'h0030);
            chk("sti_w_wr", 32'(logq[2].wr), 1);
            chk("sti_w_be", 32'(logq[2].be), 1);
        end
        @(negedge clk);
        chk("sti_mem", 32'(mem[16'h0030]), 32'h12FF);

        // clamp of levels=3 to 2 and a 0xFFFF pointer used verbatim
        run_op(1'b1, 1'b0, 16'h0040, 16'h0, 2'b11, 2'd3, -1, 20, r_cyc, r_data, i_cyc, a0, b0, b1);
        chk("clamp_resp_cyc", 32'(r_cyc), 5);
        chk("clamp_rdata", 32'(r_data), 32'h7777);
        chk("clamp_ntxn", 32'(logq.size()), 3);
        if (logq.size() == 3) begin
            chk("clamp_ptr_ffff", 32'(logq[1].addr), 32'hFFFF);
            chk("clamp_final", 32'(logq[2].addr), 32'h0050);
        end

        // abort during the first FETCH cycle, R=3
        lat = 3;
        run_op(1'b1, 1'b0, 16'h0100, 16'h0, 2'b11, 2'd1, 1, 10, r_cyc, r_data, i_cyc, a0, b0, b1);
        chk("abort_no_resp", 32'(r_cyc), 32'hFFFF_FFFF);
        chk("abort_ntxn", 32'(logq.size()), 1);
        if (logq.size() == 1) begin
            chk("abort_hold_s", 32'(logq[0].s - op_start), 1);
            chk("abort_hold_e", 32'(logq[0].e - op_start), 3);
        end
        chk("abort_idle_cyc", 32'(i_cyc), 5);
        lat = 1;
        run_op(1'b1, 1'b0, 16'h1234, 16'h0, 2'b11, 2'd0, -1, 6, r_cyc, r_data, i_cyc, a0, b0, b1);
        chk("post_abort_resp", 32'(r_cyc), 0);
        chk("post_abort_rdata", 32'(r_data), 32'hBEEF);

        // reset asserted while ACCESS is outstanding
        lat = 3;
        run_op(1'b1, 1'b0, 16'h0100, 16'h0, 2'b11, 2'd1, -1, 6, r_cyc, r_data, i_cyc, a0, b0, b1);
        chk("rsta_no_resp", 32'(r_cyc), 32'hFFFF_FFFF);
        chk("rsta_pre_read", 32'(d_bus.mem_read), 1);
        chk("rsta_pre_addr", 32'(d_bus.mem_address), 32'h2000);
        chk("rsta_pre_busy", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk("rsta_read", 32'(d_bus.mem_read), 0);
        chk("rsta_busy", 32'(busy), 0);
        chk("rsta_p_resp", 32'(p_bus.mem_resp), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        lat = 2;
        run_op(1'b1, 1'b0, 16'h0100, 16'h0, 2'b11, 2'd1, -1, 20, r_cyc, r_data, i_cyc, a0, b0, b1);
        chk("rsta_ldi_resp", 32'(r_cyc), 5);
        chk("rsta_ldi_rdata", 32'(r_data), 32'h5A5A);
        chk("rsta_ldi_ntxn", 32'(logq.size()), 2);

        chk("bus_protocol", 32'(viol), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
